crc8_frame_rx: RTL and testbench
================================

# crc8_frame_rx

Upstream framing stage of the Sigma Delta DAQ command path. Collects bytes from the serial byte receiver into frames of DATA_LENGTH_BYTES payload bytes followed by one CRC-8 byte. Streams each frame byte to the CRC8 checker (valid/last), re-arms the checker between frames and waits for its done/match verdict. Releases the payload word only on a CRC match; otherwise it flags an error.

## Interface
- DATA_LENGTH, 32: payload width in bits; must be a multiple of 8.
- TIMEOUT_CYCLES, 1000: maximum idle gap between bytes inside a frame.
- DONE_TIMEOUT, 8: maximum wait for the checker's done after the CRC byte is forwarded.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- i_rx_valid  in  1  single-cycle strobe; a byte is present on i_rx_data. There is no backpressure upstream.
- i_rx_data  in  8  received byte.
- o_rx_ready  out  1  high while bytes are accepted (RECEIVE state).
- o_crc_reset  out  1  reset to the CRC8 checker.
- o_crc_valid  out  1  byte strobe to the checker.
- o_crc_last  out  1  marks the CRC byte (last byte of the frame).
- o_crc_data  out  8  byte to the checker.
- i_crc_done  in  1  checker verdict available (level).
- i_crc_match  in  1  checker verdict: remainder 0x00.
- o_data  out  DATA_LENGTH  last good payload; the first byte received is the MSB.
- o_data_valid  out  1  one-cycle pulse when o_data updates.
- o_crc_error  out  1  one-cycle pulse: CRC mismatch, or the done timeout expired.
- o_timeout  out  1  one-cycle pulse: inter-byte timeout expired mid-frame.
- o_overrun  out  1  one-cycle pulse: a byte arrived while o_rx_ready was low and was dropped.

## Operation
- All outputs are registered.
- Reset values:
  - o_crc_reset=1.
  - All other outputs 0, including o_data=0.
  - State=ARM, byte counter=0.
- FSM:
  - ARM (1 cycle): o_crc_reset=1 → PRIME.
  - PRIME (1 cycle): o_crc_reset=0. Lets the checker leave its IDLE state. → RECEIVE.
  - RECEIVE, on each i_rx_valid:
    - shift i_rx_data into the payload shift register (non-CRC bytes only);
    - forward the byte to the checker next cycle (o_crc_valid=1, o_crc_data=byte);
    - increment the byte counter; restart the gap counter.
    - If the byte is number DATA_LENGTH_BYTES+1 (the CRC byte): o_crc_last=1 with it → WAIT_CRC.
  - WAIT_CRC, on i_crc_done:
    - i_crc_match=1: o_data ← shift register, o_data_valid pulse.
    - i_crc_match=0: o_crc_error pulse.
    - Either way → ARM.
    - If no done within DONE_TIMEOUT cycles: o_crc_error pulse → ARM.
- Gap counter runs in RECEIVE only while byte counter > 0.
  - Reaching TIMEOUT_CYCLES: o_timeout pulse, shift register discarded, → ARM.
  - No timeout while waiting for the first byte of a frame.
- Bytes with i_rx_valid while not in RECEIVE (ARM, PRIME, WAIT_CRC) are dropped with an o_overrun pulse; state is not otherwise affected.
- o_data holds its previous value on error, timeout and overrun.
- o_crc_valid and o_crc_last are never high in ARM or PRIME.
- Reset mid-frame: partial frame discarded, o_data←0, o_crc_reset high on the next cycle; no error pulse.

## Timing
- Let T be the cycle in which the CRC byte is sampled on i_rx_valid.
- T+1: o_crc_valid=o_crc_last=1.
- Checker raises i_crc_done at T+3 (checker nominal latency).
- T+4: o_data_valid or o_crc_error pulse; state ARM (o_crc_reset=1).
- T+5: PRIME.
- T+6: o_rx_ready=1; the earliest next-frame byte is accepted.
- Minimum frame-to-frame spacing: 6 cycles after the CRC byte. Bytes at T+1..T+5 are overruns.
- After reset release: ARM, then PRIME; o_rx_ready=1 in the third cycle.
- Data path latency i_rx → o_crc_*: exactly 1 cycle.
- Timeout: o_timeout asserts TIMEOUT_CYCLES+1 cycles after the last accepted byte, counting that byte's cycle as 0.

## Test plan
- Valid frame: bytes 0x12,0x34,0x56,0x78 + the correct CRC byte from the reference model (init 0x0D, reflected poly 0xC6, LSB first) → o_data=0x12345678, one o_data_valid pulse at T+4, no error pulses.
- Same frame with CRC byte XOR 0x01 → o_crc_error pulse at T+4, o_data unchanged, o_rx_ready high at T+6.
- Two bytes, then silence for TIMEOUT_CYCLES+2 cycles → exactly one o_timeout pulse. A following valid frame decodes correctly.
- Valid frame followed by a stray byte at T+2 → one o_overrun pulse. The frame still reports o_data_valid. The next frame, starting T+6, is accepted.
- Reset asserted after the third payload byte, then a full valid frame → no pulses from the partial frame; new payload reported.
- Back-to-back valid frames 0xDEADBEEF and 0x00000001 at minimum spacing → two o_data_valid pulses, correct words, zero overruns.

Source files
------------

// File: rtl/crc8_frame_rx.sv
// Frame receiver for the Sigma Delta DAQ command path: collects payload bytes plus a CRC-8 byte,
// streams them to an external CRC8 checker and releases the payload word only on a CRC match.
module crc8_frame_rx #(
  parameter int DATA_LENGTH    = 32,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int DONE_TIMEOUT   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_rx_valid,
  input  logic [7:0]             i_rx_data,
  output logic                   o_rx_ready,
  output logic                   o_crc_reset,
  output logic                   o_crc_valid,
  output logic                   o_crc_last,
  output logic [7:0]             o_crc_data,
  input  logic                   i_crc_done,
  input  logic                   i_crc_match,
  output logic [DATA_LENGTH-1:0] o_data,
  output logic                   o_data_valid,
  output logic                   o_crc_error,
  output logic                   o_timeout,
  output logic                   o_overrun
);

  localparam int NBYTES = DATA_LENGTH / 8;
  localparam int BW     = $clog2(NBYTES + 2);
  localparam int GW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW     = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [1:0] {ARM, PRIME, RECEIVE, WAIT_CRC} state_t;

  state_t                 state, state_next;
  logic [BW-1:0]          byte_cnt;
  logic [GW-1:0]          gap_cnt;
  logic [DW-1:0]          wait_cnt;
  logic [DATA_LENGTH-1:0] shreg;

  logic accept, last_byte, gap_expired, done_expired, verdict_ok, verdict_bad;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= ARM;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    last_byte    = 1'b0;
    gap_expired  = 1'b0;
    done_expired = 1'b0;
    verdict_ok   = 1'b0;
    verdict_bad  = 1'b0;
    unique case (state)
      ARM:   state_next = PRIME;
      PRIME: state_next = RECEIVE;
      RECEIVE: begin
        if (i_rx_valid) begin
          accept = 1'b1;
          if (byte_cnt == BW'(NBYTES)) begin
            last_byte  = 1'b1;
            state_next = WAIT_CRC;
          end
        end else if (byte_cnt != '0 && gap_cnt == GW'(TIMEOUT_CYCLES)) begin
          gap_expired = 1'b1;
          state_next  = ARM;
        end
      end
      WAIT_CRC: begin
        if (i_crc_done) begin
          verdict_ok  = i_crc_match;
          verdict_bad = !i_crc_match;
          state_next  = ARM;
        end else if (wait_cnt == DW'(DONE_TIMEOUT - 1)) begin
          done_expired = 1'b1;
          state_next   = ARM;
        end
      end
      default: state_next = ARM;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_rx_ready   <= 1'b0;
      o_crc_reset  <= 1'b1;
      o_crc_valid  <= 1'b0;
      o_crc_last   <= 1'b0;
      o_crc_data   <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_crc_error  <= 1'b0;
      o_timeout    <= 1'b0;
      o_overrun    <= 1'b0;
      byte_cnt     <= '0;
      gap_cnt      <= '0;
      wait_cnt     <= '0;
      shreg        <= '0;
    end else begin
      o_rx_ready   <= (state_next == RECEIVE);
      o_crc_reset  <= (state_next == ARM);
      o_crc_valid  <= accept;
      o_crc_last   <= last_byte;
      o_data_valid <= verdict_ok;
      o_crc_error  <= verdict_bad | done_expired;
      o_timeout    <= gap_expired;
      o_overrun    <= i_rx_valid && (state != RECEIVE);

      if (accept) begin
        o_crc_data <= i_rx_data;
        byte_cnt   <= byte_cnt + 1'b1;
        gap_cnt    <= GW'(1);
        if (!last_byte) shreg <= (shreg << 8) | DATA_LENGTH'(i_rx_data);
      end else if (state == RECEIVE && byte_cnt != '0) begin
        gap_cnt <= gap_cnt + 1'b1;
      end

      // Re-arming drops whatever a timed-out or finished frame left behind.
      if (state == ARM) begin
        byte_cnt <= '0;
        gap_cnt  <= '0;
        shreg    <= '0;
      end

      if (state == WAIT_CRC) wait_cnt <= wait_cnt + 1'b1;
      else                   wait_cnt <= '0;

      if (verdict_ok) o_data <= shreg;
    end
  end

endmodule

// File: tb/tb_crc8_frame_rx.sv
// Self-checking bench for crc8_frame_rx with a behavioural CRC8 checker and cycle-stamped
// scoreboard queues for forwarded bytes and every pulse output.
module tb_crc8_frame_rx;

  localparam int TIMEOUT_CYCLES = 1000;
  localparam int DONE_TIMEOUT   = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        o_rx_ready, o_crc_reset, o_crc_valid, o_crc_last;
  logic [7:0]  o_crc_data;
  logic        i_crc_done, i_crc_match;
  logic [31:0] o_data;
  logic        o_data_valid, o_crc_error, o_timeout, o_overrun;

  crc8_frame_rx #(
    .DATA_LENGTH(32), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready),
    .o_crc_reset(o_crc_reset), .o_crc_valid(o_crc_valid), .o_crc_last(o_crc_last),
    .o_crc_data(o_crc_data), .i_crc_done(i_crc_done), .i_crc_match(i_crc_match),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_crc_error(o_crc_error),
    .o_timeout(o_timeout), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 8'hC6) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] crc_of(input logic [31:0] w);
    logic [7:0] c;
    c = 8'h0D;
    for (int i = 3; i >= 0; i--) c = crc8_byte(c, w[8*i +: 8]);
    return c;
  endfunction

  // Behavioural CRC8 checker: done rises two cycles after the last byte strobe.
  logic [7:0] mdl_crc;
  logic       mdl_pend;
  always @(posedge clk) begin
    if (o_crc_reset) begin
      mdl_crc     <= 8'h0D;
      mdl_pend    <= 1'b0;
      i_crc_done  <= 1'b0;
      i_crc_match <= 1'b0;
    end else begin
      if (mdl_pend) begin
        i_crc_done  <= 1'b1;
        i_crc_match <= (mdl_crc == 8'h00);
        mdl_pend    <= 1'b0;
      end
      if (o_crc_valid) begin
        mdl_crc <= crc8_byte(mdl_crc, o_crc_data);
        if (o_crc_last) mdl_pend <= 1'b1;
      end
    end
  end

  typedef struct { int cyc; logic [7:0] b; logic last; } fwd_t;
  typedef struct { int cyc; logic [31:0] w; } word_t;

  fwd_t  fwd_q[$];
  word_t data_q[$];
  int    err_q[$];
  int    to_q[$];
  int    ovr_q[$];

  fwd_t  mon_f;
  word_t mon_w;
  int    mon_c;

  always @(negedge clk) begin
    if (o_crc_valid) begin
      if (fwd_q.size() == 0) check("fwd_unexpected", 64'(1), 64'(0));
      else begin
        mon_f = fwd_q.pop_front();
        check("fwd_cycle", 64'(cyc), 64'(mon_f.cyc));
        check("fwd_data", 64'(o_crc_data), 64'(mon_f.b));
        check("fwd_last", 64'(o_crc_last), 64'(mon_f.last));
      end
    end else if (o_crc_last) check("last_without_valid", 64'(1), 64'(0));
    if (o_data_valid) begin
      if (data_q.size() == 0) check("data_valid_unexpected", 64'(1), 64'(0));
      else begin
        mon_w = data_q.pop_front();
        check("data_valid_cycle", 64'(cyc), 64'(mon_w.cyc));
        check("data_word", 64'(o_data), 64'(mon_w.w));
      end
    end
    if (o_crc_error) begin
      if (err_q.size() == 0) check("crc_error_unexpected", 64'(1), 64'(0));
      else begin mon_c = err_q.pop_front(); check("crc_error_cycle", 64'(cyc), 64'(mon_c)); end
    end
    if (o_timeout) begin
      if (to_q.size() == 0) check("timeout_unexpected", 64'(1), 64'(0));
      else begin mon_c = to_q.pop_front(); check("timeout_cycle", 64'(cyc), 64'(mon_c)); end
    end
    if (o_overrun) begin
      if (ovr_q.size() == 0) check("overrun_unexpected", 64'(1), 64'(0));
      else begin mon_c = ovr_q.pop_front(); check("overrun_cycle", 64'(cyc), 64'(mon_c)); end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    next_cycle();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_rx_ready && n < 50) begin
      next_cycle();
      n++;
    end
    if (!o_rx_ready) check("ready_wait", 64'(o_rx_ready), 64'(1));
  endtask

  // Sends a frame in consecutive cycles; t returns the cycle the CRC byte was sampled.
  task automatic send_frame(input logic [31:0] w, input logic [7:0] flip, output int t);
    logic [7:0] c;
    for (int i = 3; i >= 0; i--) begin
      fwd_q.push_back('{cyc + 1, w[8*i +: 8], 1'b0});
      drive_byte(w[8*i +: 8]);
    end
    c = crc_of(w) ^ flip;
    t = cyc;
    fwd_q.push_back('{t + 1, c, 1'b1});
    if (flip == 8'h00) data_q.push_back('{t + 4, w});
    else               err_q.push_back(t + 4);
    drive_byte(c);
  endtask

  task automatic do_reset(input int n);
    int r;
    reset = 1'b1;
    next_cycle();
    check("rst_crc_reset", 64'(o_crc_reset), 64'(1));
    check("rst_data", 64'(o_data), 64'(0));
    check("rst_pulses", 64'({o_rx_ready, o_crc_valid, o_crc_last, o_data_valid,
                             o_crc_error, o_timeout, o_overrun}), 64'(0));
    repeat (n - 1) next_cycle();
    reset = 1'b0;
    r = cyc;
    check("arm_crc_reset", 64'(o_crc_reset), 64'(1));
    next_cycle();
    check("prime_crc_reset", 64'(o_crc_reset), 64'(0));
    check("prime_ready", 64'(o_rx_ready), 64'(0));
    next_cycle();
    check("third_cycle_ready", 64'(o_rx_ready), 64'(1));
    check("third_cycle_index", 64'(cyc), 64'(r + 2));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    next_cycle();
    do_reset(3);

    // Valid frame.
    wait_ready();
    send_frame(32'h12345678, 8'h00, t);
    repeat (8) next_cycle();

    // Corrupted CRC byte: error pulse, word held, receiver re-armed at T+6.
    wait_ready();
    send_frame(32'h12345678, 8'h01, t);
    while (cyc < t + 5) next_cycle();
    check("err_ready_t5", 64'(o_rx_ready), 64'(0));
    next_cycle();
    check("err_ready_t6", 64'(o_rx_ready), 64'(1));
    check("err_data_held", 64'(o_data), 64'(32'h12345678));

    // Two bytes then silence: one inter-byte timeout, then a clean frame.
    wait_ready();
    fwd_q.push_back('{cyc + 1, 8'hAA, 1'b0});
    drive_byte(8'hAA);
    t = cyc;
    fwd_q.push_back('{t + 1, 8'hBB, 1'b0});
    to_q.push_back(t + TIMEOUT_CYCLES + 1);
    drive_byte(8'hBB);
    repeat (TIMEOUT_CYCLES + 2) next_cycle();
    check("timeout_data_held", 64'(o_data), 64'(32'h12345678));
    wait_ready();
    send_frame(32'hCAFEF00D, 8'h00, t);
    repeat (8) next_cycle();

    // Stray byte at T+2 is an overrun; next frame at T+6 is accepted.
    wait_ready();
    send_frame(32'h0BADC0DE, 8'h00, t);
    next_cycle();
    ovr_q.push_back(t + 3);
    drive_byte(8'h77);
    while (cyc < t + 6) next_cycle();
    send_frame(32'h13579BDF, 8'h00, t);
    repeat (8) next_cycle();

    // Reset after the third payload byte, then a full frame.
    wait_ready();
    for (int i = 0; i < 3; i++) begin
      fwd_q.push_back('{cyc + 1, 8'h40 + 8'(i), 1'b0});
      drive_byte(8'h40 + 8'(i));
    end
    do_reset(2);
    send_frame(32'hA5A55A5A, 8'h00, t);
    repeat (8) next_cycle();

    // Back-to-back frames at minimum spacing.
    wait_ready();
    send_frame(32'hDEADBEEF, 8'h00, t);
    while (cyc < t + 6) next_cycle();
    send_frame(32'h00000001, 8'h00, t);
    repeat (20) next_cycle();
    check("final_word", 64'(o_data), 64'(32'h00000001));

    check("fwd_q_drained", 64'(fwd_q.size()), 64'(0));
    check("data_q_drained", 64'(data_q.size()), 64'(0));
    check("err_q_drained", 64'(err_q.size()), 64'(0));
    check("to_q_drained", 64'(to_q.size()), 64'(0));
    check("ovr_q_drained", 64'(ovr_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
